// File: rtl/sigma_delta_sequencer.sv
// Sample scheduler for the sigma-delta modulator: FIFO-buffered samples, each held OSR clocks.
// Build option SD_SEQ_MIDSCALE_EN: on underflow present mid-scale instead of repeating the last sample.
module sigma_delta_sequencer #(
    parameter int VALUE_WIDTH = 8,
    parameter int OSR_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [OSR_WIDTH-1:0]   osr,
    input  logic                   s_valid,
    input  logic [VALUE_WIDTH-1:0] s_data,
    output logic                   s_ready,
    output logic                   mod_enable,
    output logic [VALUE_WIDTH-1:0] mod_value,
    output logic                   busy,
    output logic                   underflow,
    output logic [1:0]             fsm_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic [VALUE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [VALUE_WIDTH-1:0] head;

    state_t                 state;
    logic [OSR_WIDTH-1:0]   osr_q;
    logic [OSR_WIDTH-1:0]   cnt;
    logic                   stop_pend;

    // Handshake: a word transfers on every rising edge where s_valid && s_ready;
    // s_ready depends only on the registered fill level (and is low during reset),
    // never on s_valid, and s_data is ignored whenever no transfer happens.
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign s_ready = !reset && !full;
    assign push    = s_valid && s_ready;
    assign head    = mem[rd_ptr];

    // The FSM is the only consumer: LOAD takes the first sample, RUN takes one per boundary
    // unless a stop is pending or arriving on that boundary.
    assign pop = !empty &&
                 ((state == LOAD && !stop) ||
                  (state == RUN && cnt == '0 && !stop_pend && !stop));

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            osr_q      <= OSR_WIDTH'(1);
            cnt        <= '0;
            stop_pend  <= 1'b0;
            mod_enable <= 1'b0;
            mod_value  <= '0;
            busy       <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            underflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        osr_q     <= (osr == '0) ? OSR_WIDTH'(1) : osr;
                        stop_pend <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (pop) begin
                        mod_value  <= head;
                        cnt        <= osr_q - OSR_WIDTH'(1);
                        mod_enable <= 1'b1;
                        state      <= RUN;
                    end
                end

                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - OSR_WIDTH'(1);
                        if (stop) begin
                            stop_pend <= 1'b1;
                        end
                    end else if (stop_pend || stop) begin
                        mod_enable <= 1'b0;
                        mod_value  <= '0;
                        stop_pend  <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (pop) begin
                        mod_value <= head;
                        cnt       <= osr_q - OSR_WIDTH'(1);
                    end else begin
                        // Starved boundary: keep the modulator running on a substitute value.
                        underflow <= 1'b1;
                        cnt       <= osr_q - OSR_WIDTH'(1);
`ifdef SD_SEQ_MIDSCALE_EN
                        mod_value <= {1'b1, {(VALUE_WIDTH-1){1'b0}}};
`else
                        mod_value <= mod_value;
`endif
                    end
                end

                default: begin
                    mod_enable <= 1'b0;
                    mod_value  <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigma_delta_sequencer.sv
// Self-checking bench for sigma_delta_sequencer: expected per-cycle {underflow, mod_value}
// are queued as stimulus is driven and compared whenever the modulator is enabled.
module tb_sigma_delta_sequencer;

    localparam int VW = 8;
    localparam int OW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [OW-1:0] osr = '0;
    logic          s_valid = 1'b0;
    logic [VW-1:0] s_data = '0;
    logic          s_ready;
    logic          mod_enable;
    logic [VW-1:0] mod_value;
    logic          busy;
    logic          underflow;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;

    logic [VW:0]   exp_q[$];
    logic [VW-1:0] model_fifo[$];
    logic [VW-1:0] last_sample = '0;

    sigma_delta_sequencer #(
        .VALUE_WIDTH(VW),
        .OSR_WIDTH  (OW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .osr       (osr),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mod_enable(mod_enable),
        .mod_value (mod_value),
        .busy      (busy),
        .underflow (underflow),
        .fsm_state (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [VW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        check("push_ready", 32'(s_ready), 32'd1);
        model_fifo.push_back(d);
        step();
        s_valid = 1'b0;
    endtask

    task automatic start_seq(input logic [OW-1:0] o);
        start = 1'b1;
        osr   = o;
        step();
        start = 1'b0;
        osr   = OW'($urandom_range(0, 65535));
    endtask

    task automatic stop_seq();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic expect_samples(input int n, input int o);
        repeat (n) begin
            last_sample = model_fifo.pop_front();
            repeat (o) exp_q.push_back({1'b0, last_sample});
        end
    endtask

    task automatic expect_underflow(input int n, input int o);
        logic [VW-1:0] sub;
`ifdef SD_SEQ_MIDSCALE_EN
        sub = {1'b1, {(VW-1){1'b0}}};
`else
        sub = last_sample;
`endif
        repeat (n) begin
            exp_q.push_back({1'b1, sub});
            repeat (o - 1) exp_q.push_back({1'b0, sub});
        end
        last_sample = sub;
    endtask

    task automatic wait_size(input int n, input int budget);
        int k = 0;
        while (exp_q.size() != n && k < budget) begin
            step();
            k++;
        end
        check("wait_size", 32'(exp_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (mod_enable) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 32'(mod_enable), 32'd0);
                end else begin
                    check("out", 32'({underflow, mod_value}), 32'(exp_q.pop_front()));
                end
            end else begin
                check("idle_value", 32'(mod_value), 32'd0);
                check("idle_underflow", 32'(underflow), 32'd0);
            end
        end
    end

    initial begin
        // reset state
        step();
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_enable", 32'(mod_enable), 32'd0);
        check("rst_value", 32'(mod_value), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(s_ready), 32'd1);

        // osr=4, three samples then two underflow substitutes, then stop
        push_word(8'h10);
        push_word(8'h20);
        push_word(8'h30);
        expect_samples(3, 4);
        expect_underflow(2, 4);
        start_seq(16'd4);
        check("t1_load_enable", 32'(mod_enable), 32'd0);
        check("t1_load_state", 32'(fsm_state), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        step();
        check("t1_enable_rise", 32'(mod_enable), 32'd1);
        check("t1_run_state", 32'(fsm_state), 32'd2);
        wait_size(2, 100);
        stop_seq();
        wait_idle(20);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // osr=3, stop one cycle into a sample; the next sample stays queued
        push_word(8'h41);
        push_word(8'h42);
        push_word(8'h43);
        expect_samples(2, 3);
        start_seq(16'd3);
        wait_size(3, 100);
        stop_seq();
        wait_idle(20);
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_idle_state", 32'(fsm_state), 32'd0);
        expect_samples(1, 3);
        start_seq(16'd3);
        wait_size(2, 100);
        stop_seq();
        wait_idle(20);
        check("t3_retained_drained", 32'(exp_q.size()), 32'd0);

        // fill to full while idle; extra words must be refused
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = VW'(8'h50 + i);
            check("t4_fill_ready", 32'(s_ready), 32'(i < FD));
            if (i < FD) model_fifo.push_back(s_data);
            step();
        end
        s_valid = 1'b0;
        check("t4_full_ready", 32'(s_ready), 32'd0);
        expect_samples(4, 2);
        expect_underflow(1, 2);
        start_seq(16'd2);
        check("t4_ready_before_pop", 32'(s_ready), 32'd0);
        step();
        check("t4_ready_after_pop", 32'(s_ready), 32'd1);
        check("t4_enable", 32'(mod_enable), 32'd1);
        wait_size(1, 100);
        stop_seq();
        check("t4_stop_at_boundary", 32'(busy), 32'd0);
        wait_idle(20);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // osr=0 treated as 1; start with an empty FIFO waits in LOAD
        start_seq(16'd0);
        repeat (3) begin
            check("t5_wait_busy", 32'(busy), 32'd1);
            check("t5_wait_state", 32'(fsm_state), 32'd1);
            check("t5_wait_enable", 32'(mod_enable), 32'd0);
            step();
        end
        push_word(8'h7e);
        check("t5_not_yet", 32'(mod_enable), 32'd0);
        expect_samples(1, 1);
        expect_underflow(2, 1);
        step();
        check("t5_enable", 32'(mod_enable), 32'd1);
        wait_size(1, 50);
        stop_seq();
        check("t5_stopped", 32'(busy), 32'd0);
        wait_idle(20);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // reset mid-RUN discards the queue
        push_word(8'h61);
        push_word(8'h62);
        push_word(8'h63);
        expect_samples(3, 5);
        start_seq(16'd5);
        step();
        step();
        reset = 1'b1;
        exp_q.delete();
        model_fifo.delete();
        #1;
        check("t6_ready_in_reset", 32'(s_ready), 32'd0);
        step();
        check("t6_enable", 32'(mod_enable), 32'd0);
        check("t6_value", 32'(mod_value), 32'd0);
        check("t6_underflow", 32'(underflow), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_state", 32'(fsm_state), 32'd0);
        reset = 1'b0;
        #1;
        check("t6_ready_after", 32'(s_ready), 32'd1);
        start_seq(16'd2);
        repeat (5) begin
            check("t6_load_busy", 32'(busy), 32'd1);
            check("t6_load_state", 32'(fsm_state), 32'd1);
            check("t6_load_enable", 32'(mod_enable), 32'd0);
            step();
        end
        stop_seq();
        check("t6_stop_in_load", 32'(busy), 32'd0);
        check("t6_final_state", 32'(fsm_state), 32'd0);
        step();
        check("final_drained", 32'(exp_q.size()), 32'd0);

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
